// File: rtl/loop_bracket_scanner.sv
// loop_bracket_scanner
// Matching-bracket search sequencer for the BF core. It steps the IP one cell
// per fetch and drives the external BCD loop-depth counter. It stops on the
// bracket that closes the loop while the depth is 00.
// Optional feature macro: LOOP_SCAN_TIMEOUT_EN. When it is defined, the search
// aborts after MAX_STEPS fetches.
module loop_bracket_scanner #(
    parameter int                    INSN_WIDTH = 4,
    parameter logic [INSN_WIDTH-1:0] OPEN_CODE  = 4'h6,
    parameter logic [INSN_WIDTH-1:0] CLOSE_CODE = 4'h7,
    parameter logic [15:0]           MAX_STEPS  = 16'd9999
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Request,
    input  logic                  Dir,
    output logic                  IpStep,
    output logic                  IpReverse,
    input  logic                  InsnValid,
    input  logic [INSN_WIDTH-1:0] Insn,
    output logic                  LoopClear_n,
    output logic                  LoopStep,
    output logic                  LoopReverse,
    input  logic [7:0]            LoopCount,
    input  logic                  LoopOverflow,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ADVANCE, S_WAIT, S_EVAL, S_SETTLE, S_DONE, S_ERROR
    } state_t;

    state_t state_q, state_d, fetch_next;

    logic                  dir_q;
    logic                  step_q;     // captured opcode moves the depth counter
    logic                  match_q;    // captured opcode is the matching bracket
    logic                  busy_q, done_q, err_q, ip_step_q, ip_rev_q;
    logic                  clr_n_q, loop_step_q, loop_rev_q;
    logic                  start, busy_d, capture, hit_same, hit_other, depth_zero;
    logic                  tmo_hit;
    logic [INSN_WIDTH-1:0] same_code, other_code;

    // A start is accepted in any state that reports Busy==0.
    assign start = Request && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

    assign same_code  = dir_q ? CLOSE_CODE : OPEN_CODE;
    assign other_code = dir_q ? OPEN_CODE  : CLOSE_CODE;
    assign hit_same   = (Insn == same_code);
    assign hit_other  = (Insn == other_code);
    assign depth_zero = (LoopCount == 8'h00);
    assign capture    = (state_q == S_WAIT) && InsnValid;

`ifdef LOOP_SCAN_TIMEOUT_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] fetch_cnt_eff;

    // Fetch counter: cleared in CLEAR, counts every IpStep cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                   fetch_cnt_q <= 16'd0;
        else if (state_q == S_CLEAR)   fetch_cnt_q <= 16'd0;
        else if (state_q == S_ADVANCE) fetch_cnt_q <= fetch_cnt_q + 16'd1;
    end

    // Leaving CLEAR, the counter has not cleared yet, so treat it as zero.
    assign fetch_cnt_eff = (state_q == S_CLEAR) ? 16'd0 : fetch_cnt_q;
    assign tmo_hit       = (fetch_cnt_eff == MAX_STEPS);
`else
    // There is no fetch limit. MAX_STEPS is referenced only so the parameter stays declared.
    assign tmo_hit = 1'b0 && (MAX_STEPS != 16'd0);
`endif

    // Every fetch goes through this choice. The timeout is decided before entering
    // ADVANCE, so an aborted fetch never pulses IpStep.
    assign fetch_next = tmo_hit ? S_ERROR : S_ADVANCE;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CLEAR;
            S_CLEAR:   state_d = fetch_next;
            S_ADVANCE: state_d = S_WAIT;
            S_WAIT:    if (InsnValid) state_d = S_EVAL;
            S_EVAL: begin
                if (step_q)       state_d = S_SETTLE;
                else if (match_q) state_d = S_DONE;
                else              state_d = fetch_next;
            end
            S_SETTLE:  state_d = LoopOverflow ? S_ERROR : fetch_next;
            S_DONE,
            S_ERROR:   state_d = start ? S_CLEAR : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d == S_CLEAR) || (state_d == S_ADVANCE) || (state_d == S_WAIT) ||
                    (state_d == S_EVAL)  || (state_d == S_SETTLE);

    // State register, plus registered outputs decoded from the next state.
    // LoopStep is raised on entry to EVAL, so the counter has updated before SETTLE samples Overflow.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ip_step_q   <= 1'b0;
            ip_rev_q    <= 1'b0;
            clr_n_q     <= 1'b1;
            loop_step_q <= 1'b0;
            loop_rev_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= (state_d == S_DONE);
            ip_step_q <= (state_d == S_ADVANCE);
            clr_n_q   <= (state_d != S_CLEAR);
            if (start) dir_q <= Dir;
            ip_rev_q  <= busy_d ? (start ? Dir : dir_q) : 1'b0;
            if (state_d == S_ERROR) err_q <= 1'b1;
            else if (start)         err_q <= 1'b0;
            if (capture) begin
                step_q  <= hit_same || (hit_other && !depth_zero);
                match_q <= hit_other && depth_zero;
            end
            loop_step_q <= capture && (hit_same || (hit_other && !depth_zero));
            if (capture && (hit_same || (hit_other && !depth_zero)))
                loop_rev_q <= hit_other;
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Err         = err_q;
    assign IpStep      = ip_step_q;
    assign IpReverse   = ip_rev_q;
    assign LoopClear_n = clr_n_q;
    assign LoopStep    = loop_step_q;
    assign LoopReverse = loop_rev_q;

endmodule

// File: tb/tb_loop_bracket_scanner.sv
// tb_loop_bracket_scanner
// Directed bench for loop_bracket_scanner. It models the program memory with a
// 1-cycle InsnValid and the two-digit BCD depth counter with a sticky overflow.
// Build with LOOP_SCAN_TIMEOUT_EN to exercise the fetch limit (MAX_STEPS=8).
module tb_loop_bracket_scanner;

    localparam logic [3:0] OP = 4'h6, CL = 4'h7, PL = 4'h1, MI = 4'h2;
`ifdef LOOP_SCAN_TIMEOUT_EN
    localparam int         OVF_FETCH = 8;
    localparam logic [7:0] OVF_DEPTH = 8'h08;
`else
    localparam int         OVF_FETCH = 100;
    localparam logic [7:0] OVF_DEPTH = 8'h99;
`endif

    logic       Clk, Rst_n, Request, Dir, IpStep, IpReverse, InsnValid;
    logic [3:0] Insn;
    logic       LoopClear_n, LoopStep, LoopReverse, LoopOverflow, Busy, Done, Err;
    logic [7:0] LoopCount;

    logic [3:0] mem [0:255];
    logic [7:0] ip, start_ip;
    logic [7:0] lcnt;
    logic       lovf;
    logic       clr_n;

    int checks = 0;
    int errors = 0;
    int cyc, nip, nls, nbad;
    logic gd, ge;

    loop_bracket_scanner #(.INSN_WIDTH(4), .OPEN_CODE(4'h6), .CLOSE_CODE(4'h7), .MAX_STEPS(16'd8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Request(Request), .Dir(Dir),
        .IpStep(IpStep), .IpReverse(IpReverse), .InsnValid(InsnValid), .Insn(Insn),
        .LoopClear_n(LoopClear_n), .LoopStep(LoopStep), .LoopReverse(LoopReverse),
        .LoopCount(LoopCount), .LoopOverflow(LoopOverflow),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Program memory and IP chain: the IP is loaded on an accepted start, then steps on IpStep.
    assign Insn = mem[ip];
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) InsnValid <= 1'b0;
        else begin
            InsnValid <= IpStep;
            if (Request && !Busy) ip <= start_ip;
            else if (IpStep)      ip <= IpReverse ? ip - 8'd1 : ip + 8'd1;
        end
    end

    // Two-digit BCD depth counter with a sticky limit flag at 99.
    assign clr_n        = LoopClear_n & Rst_n;
    assign LoopCount    = lcnt;
    assign LoopOverflow = lovf;
    always @(posedge Clk or negedge clr_n) begin
        if (!clr_n) begin
            lcnt <= 8'h00;
            lovf <= 1'b0;
        end else if (LoopStep) begin
            if (!LoopReverse) begin
                if (lcnt == 8'h99)       lovf <= 1'b1;
                else if (lcnt[3:0] == 9) lcnt <= {lcnt[7:4] + 4'd1, 4'd0};
                else                     lcnt <= lcnt + 8'd1;
            end else if (lcnt != 8'h00) begin
                if (lcnt[3:0] == 0)      lcnt <= {lcnt[7:4] - 4'd1, 4'd9};
                else                     lcnt <= lcnt - 8'd1;
            end
        end
    end

    // Start one search, call on a negedge. If poke>0, Request is pulsed again at that cycle while Busy.
    task automatic run_scan(input logic [7:0] sip, input logic d, input int poke);
        start_ip = sip;
        Dir      = d;
        Request  = 1'b1;
        cyc = 0; nip = 0; nls = 0; nbad = 0; gd = 1'b0; ge = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            cyc++;
            Request = (poke != 0) && (cyc == poke);
            if (IpStep) nip++;
            if (LoopStep) nls++;
            if (IpStep && LoopStep) nbad++;
            if (Busy && (Done || Err)) nbad++;
            if (Busy && IpReverse !== d) nbad++;
            if (Done || Err) begin
                gd = Done;
                ge = Err;
                break;
            end
        end
        Request = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Request = 1'b0; Dir = 1'b0; start_ip = 8'd0;
        repeat (2) @(negedge Clk);
        checks++; if (Busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0)        begin errors++; $display("FAIL rst_done: got %b expected 0", Done); end
        checks++; if (Err !== 1'b0)         begin errors++; $display("FAIL rst_err: got %b expected 0", Err); end
        checks++; if (IpStep !== 1'b0)      begin errors++; $display("FAIL rst_ipstep: got %b expected 0", IpStep); end
        checks++; if (LoopStep !== 1'b0)    begin errors++; $display("FAIL rst_loopstep: got %b expected 0", LoopStep); end
        checks++; if (LoopClear_n !== 1'b1) begin errors++; $display("FAIL rst_clear_n: got %b expected 1", LoopClear_n); end
        checks++; if (IpReverse !== 1'b0)   begin errors++; $display("FAIL rst_iprev: got %b expected 0", IpReverse); end
        checks++; if (LoopReverse !== 1'b0) begin errors++; $display("FAIL rst_looprev: got %b expected 0", LoopReverse); end
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    // "[ ]" at 20: CLEAR, ADVANCE, WAIT, EVAL, DONE gives Done 5 cycles after Request.
    task automatic test_adjacent();
        run_scan(8'd20, 1'b0, 0);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL adj_done: got %b expected 1", gd); end
        checks++; if (cyc != 5)    begin errors++; $display("FAIL adj_latency: got %0d expected 5", cyc); end
        checks++; if (nip != 1)    begin errors++; $display("FAIL adj_ipsteps: got %0d expected 1", nip); end
        @(negedge Clk);
    endtask

    // "[ + ]" at 10: two fetches, no depth activity.
    task automatic test_skip_fwd();
        run_scan(8'd10, 1'b0, 0);
        checks++; if (gd !== 1'b1)       begin errors++; $display("FAIL fwd_done: got %b expected 1", gd); end
        checks++; if (nip != 2)          begin errors++; $display("FAIL fwd_ipsteps: got %0d expected 2", nip); end
        checks++; if (nls != 0)          begin errors++; $display("FAIL fwd_loopsteps: got %0d expected 0", nls); end
        checks++; if (LoopCount !== 8'h00) begin errors++; $display("FAIL fwd_depth: got %h expected 00", LoopCount); end
        checks++; if (ip !== 8'd12)      begin errors++; $display("FAIL fwd_ip: got %0d expected 12", ip); end
        checks++; if (nbad != 0)         begin errors++; $display("FAIL fwd_protocol: got %0d violations expected 0", nbad); end
        @(negedge Clk);
    endtask

    // "[ [ - ] ]" at 30: depth goes up and then down, and the match is on the 4th fetch.
    task automatic test_nested();
        run_scan(8'd30, 1'b0, 0);
        checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL nest_result: got done=%b err=%b expected done=1 err=0", gd, ge); end
        checks++; if (nip != 4)            begin errors++; $display("FAIL nest_ipsteps: got %0d expected 4", nip); end
        checks++; if (nls != 2)            begin errors++; $display("FAIL nest_loopsteps: got %0d expected 2", nls); end
        checks++; if (LoopCount !== 8'h00) begin errors++; $display("FAIL nest_depth: got %h expected 00", LoopCount); end
        checks++; if (nbad != 0)           begin errors++; $display("FAIL nest_protocol: got %0d violations expected 0", nbad); end
        @(negedge Clk);
    endtask

    // "[ [ ] + ]" at 40..44, started on the ']' at 44 and walking back to the '[' at 40.
    task automatic test_backward();
        run_scan(8'd44, 1'b1, 0);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL bwd_done: got %b expected 1", gd); end
        checks++; if (nip != 4)    begin errors++; $display("FAIL bwd_ipsteps: got %0d expected 4", nip); end
        checks++; if (nls != 2)    begin errors++; $display("FAIL bwd_loopsteps: got %0d expected 2", nls); end
        checks++; if (ip !== 8'd40) begin errors++; $display("FAIL bwd_ip: got %0d expected 40", ip); end
        checks++; if (nbad != 0)   begin errors++; $display("FAIL bwd_protocol: got %0d violations expected 0", nbad); end
        @(negedge Clk);
    endtask

    // A Request arriving mid-search must not restart it.
    task automatic test_back_to_back();
        run_scan(8'd30, 1'b0, 3);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", gd); end
        checks++; if (nip != 4)    begin errors++; $display("FAIL b2b_ipsteps: got %0d expected 4", nip); end
        checks++; if (ip !== 8'd34) begin errors++; $display("FAIL b2b_ip: got %0d expected 34", ip); end
        @(negedge Clk);
    endtask

    // 100 nested '[' after the start bracket: the 100th overflows the depth counter.
    task automatic test_overflow();
        run_scan(8'd120, 1'b0, 0);
        checks++; if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL ovf_result: got done=%b err=%b expected done=0 err=1", gd, ge); end
        checks++; if (nip != OVF_FETCH) begin errors++; $display("FAIL ovf_ipsteps: got %0d expected %0d", nip, OVF_FETCH); end
        checks++; if (nls != OVF_FETCH) begin errors++; $display("FAIL ovf_loopsteps: got %0d expected %0d", nls, OVF_FETCH); end
        checks++; if (LoopCount !== OVF_DEPTH) begin errors++; $display("FAIL ovf_depth: got %h expected %h", LoopCount, OVF_DEPTH); end
        repeat (2) @(negedge Clk);
        checks++; if (Err !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL ovf_sticky: got err=%b busy=%b expected err=1 busy=0", Err, Busy); end
        run_scan(8'd20, 1'b0, 0);
        checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL ovf_recover: got done=%b err=%b expected done=1 err=0", gd, ge); end
        @(negedge Clk);
    endtask

    // Reset pulsed while waiting for the first opcode, then a normal search.
    task automatic test_reset_mid();
        int k;
        start_ip = 8'd30; Dir = 1'b0; Request = 1'b1;
        @(negedge Clk);
        Request = 1'b0;
        k = 0;
        while (!IpStep && k < 20) begin @(negedge Clk); k++; end
        checks++; if (IpStep !== 1'b1) begin errors++; $display("FAIL rmid_ipstep: got %b expected 1", IpStep); end
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL rmid_idle: got busy=%b done=%b expected 0 0", Busy, Done); end
        checks++; if (LoopClear_n !== 1'b1 || IpStep !== 1'b0) begin errors++; $display("FAIL rmid_outs: got clear_n=%b ipstep=%b expected 1 0", LoopClear_n, IpStep); end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got busy=%b done=%b expected 0 0", Busy, Done); end
        run_scan(8'd30, 1'b0, 0);
        checks++; if (gd !== 1'b1 || nip != 4) begin errors++; $display("FAIL rmid_rerun: got done=%b ipsteps=%0d expected 1 4", gd, nip); end
        @(negedge Clk);
    endtask

`ifdef LOOP_SCAN_TIMEOUT_EN
    // Unbalanced "[ + + + ..." at 230: exactly MAX_STEPS=8 fetches, then abort.
    task automatic test_timeout();
        run_scan(8'd230, 1'b0, 0);
        checks++; if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL tmo_result: got done=%b err=%b expected done=0 err=1", gd, ge); end
        checks++; if (nip != 8) begin errors++; $display("FAIL tmo_ipsteps: got %0d expected 8", nip); end
        @(negedge Clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = PL;
        mem[10] = OP; mem[11] = PL; mem[12] = CL;
        mem[20] = OP; mem[21] = CL;
        mem[30] = OP; mem[31] = OP; mem[32] = MI; mem[33] = CL; mem[34] = CL;
        mem[40] = OP; mem[41] = OP; mem[42] = CL; mem[43] = PL; mem[44] = CL;
        for (int i = 120; i <= 220; i++) mem[i] = OP;
        mem[230] = OP;
        ip = 8'd0;

        test_reset();
        test_adjacent();
        test_skip_fwd();
        test_nested();
        test_backward();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
`ifdef LOOP_SCAN_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
